// File: rtl/spi_frame_pkg.sv
// rtl/spi_frame_pkg.sv - shared types and sizing helpers for the SPI frame transceiver
package spi_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_DATA = 3'd2,
        ST_DONE = 3'd3,
        ST_WAIT = 3'd4
    } state_t;

    // Total sampled bits in one frame: header, payload and optional parity bit.
    function automatic int frame_bits(input int hdr_w, input int nch, input int dw, input bit parity);
        return hdr_w + nch * dw + (parity ? 1 : 0);
    endfunction

    // Width of a counter that must hold the values 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - single-bit two-flop synchroniser with selectable reset value
// Ports:
//   clk  - destination clock
//   rstn - asynchronous active-low reset, both flops load RST_VAL
//   d    - asynchronous input
//   q    - synchronised output
module sync_2ff #(
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spi_frame_xcvr.sv
// rtl/spi_frame_xcvr.sv - SPI-slave frame receiver (header check + NCH samples) with DW-bit MISO return word
// Optional feature: SPI_PARITY_EN adds an even-parity bit after the payload and the par_err output.
// Ports:
//   clk, rstn    - system clock, asynchronous active-low reset
//   sck, cs, mosi- raw SPI inputs (asynchronous, cs active low, MSB first)
//   miso         - serial result word, MSB first, 0 when idle or exhausted
//   tx_data      - result word, captured when CS falls
//   rx_data      - received samples, channel 0 in the LSBs
//   frame_valid  - one-cycle strobe, rx_data carries the new frame in the same cycle
//   hdr_err      - one-cycle strobe, header mismatch
//   short_err    - one-cycle strobe, CS released before the frame completed
//   par_err      - one-cycle strobe, payload parity mismatch (SPI_PARITY_EN only)
module spi_frame_xcvr
    import spi_frame_pkg::*;
#(
    parameter int               DW       = 14,
    parameter int               NCH      = 3,
    parameter int               HDR_W    = 8,
    parameter logic [HDR_W-1:0] HDR_VAL  = 8'hA5,
    parameter bit               SCK_EDGE = 1'b0
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                sck,
    input  logic                cs,
    input  logic                mosi,
    output logic                miso,
    input  logic [DW-1:0]       tx_data,
    output logic [NCH*DW-1:0]   rx_data,
    output logic                frame_valid,
    output logic                hdr_err,
    output logic                short_err
`ifdef SPI_PARITY_EN
    ,
    output logic                par_err
`endif
);

`ifdef SPI_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int DATA_W     = NCH * DW;
    localparam int SR_W       = DATA_W + (PAR_EN ? 1 : 0);
    localparam int FRAME_BITS = frame_bits(HDR_W, NCH, DW, PAR_EN);
    localparam int CW         = cnt_width(FRAME_BITS);
    localparam int TCW        = cnt_width(DW);

    localparam logic [CW-1:0]  LAST_HDR = CW'(HDR_W - 1);
    localparam logic [CW-1:0]  LAST_BIT = CW'(FRAME_BITS - 1);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(FRAME_BITS);
    localparam logic [TCW-1:0] TX_END   = TCW'(DW);

    logic sck_s, cs_s, mosi_s;
    logic sck_d, cs_d;

    sync_2ff #(.RST_VAL(1'b0)) u_sync_sck  (.clk(clk), .rstn(rstn), .d(sck),  .q(sck_s));
    sync_2ff #(.RST_VAL(1'b1)) u_sync_cs   (.clk(clk), .rstn(rstn), .d(cs),   .q(cs_s));
    sync_2ff #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rstn(rstn), .d(mosi), .q(mosi_s));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sck_d <= 1'b0;
            cs_d  <= 1'b1;
        end else begin
            sck_d <= sck_s;
            cs_d  <= cs_s;
        end
    end

    logic sck_rise, sck_fall, sample_edge, shift_edge, cs_fall, cs_rise;
    assign sck_rise    = sck_s & ~sck_d;
    assign sck_fall    = ~sck_s & sck_d;
    assign sample_edge = SCK_EDGE ? sck_fall : sck_rise;
    assign shift_edge  = SCK_EDGE ? sck_rise : sck_fall;
    assign cs_fall     = ~cs_s & cs_d;
    assign cs_rise     = cs_s & ~cs_d;

    state_t              state, state_n;
    logic [CW-1:0]       bit_cnt, cnt_n;
    logic [HDR_W-1:0]    hdr_sr, hdr_n, hdr_next;
    logic [SR_W-1:0]     data_sr, data_n;
    logic [DW-1:0]       tx_sr;
    logic [TCW-1:0]      tx_cnt;
    logic [DATA_W-1:0]   rx_q, rx_payload;
    logic                frame_ok, ld_tx, par_ok;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = bit_cnt;
        hdr_n     = hdr_sr;
        data_n    = data_sr;
        hdr_err   = 1'b0;
        short_err = 1'b0;
        frame_ok  = 1'b0;
        ld_tx     = 1'b0;
        hdr_next  = {hdr_sr[HDR_W-2:0], mosi_s};
        case (state)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_n = ST_HDR;
                    cnt_n   = '0;
                    ld_tx   = 1'b1;
                end
            end
            ST_HDR: begin
                // CS release wins over a coincident sampling edge.
                if (cs_rise) begin
                    short_err = 1'b1;
                    state_n   = ST_IDLE;
                end else if (sample_edge) begin
                    hdr_n = hdr_next;
                    cnt_n = (bit_cnt == CNT_MAX) ? bit_cnt : bit_cnt + 1'b1;
                    if (bit_cnt == LAST_HDR) begin
                        if (hdr_next == HDR_VAL) begin
                            state_n = ST_DATA;
                        end else begin
                            hdr_err = 1'b1;
                            state_n = ST_WAIT;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (cs_rise) begin
                    short_err = 1'b1;
                    state_n   = ST_IDLE;
                end else if (sample_edge) begin
                    data_n = {data_sr[SR_W-2:0], mosi_s};
                    cnt_n  = (bit_cnt == CNT_MAX) ? bit_cnt : bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state_n = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (cs_rise) begin
                    short_err = 1'b1;
                    state_n   = ST_IDLE;
                end else begin
                    frame_ok = 1'b1;
                    state_n  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cs_rise) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // The first sample on the wire sits in the top of data_sr; rx_data wants it in the LSBs.
    always_comb begin
        rx_payload = '0;
        for (int c = 0; c < NCH; c++) begin
            rx_payload[c*DW +: DW] = data_sr[SR_W-1-c*DW -: DW];
        end
    end

`ifdef SPI_PARITY_EN
    // Payload plus parity bit must XOR to zero for even parity.
    assign par_ok  = ~(^data_sr);
    assign par_err = frame_ok & ~par_ok;
`else
    assign par_ok  = 1'b1;
`endif

    assign frame_valid = frame_ok & par_ok;
    // New payload is forwarded during the strobe cycle and held in rx_q afterwards.
    assign rx_data     = frame_valid ? rx_payload : rx_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bit_cnt <= '0;
            hdr_sr  <= '0;
            data_sr <= '0;
            rx_q    <= '0;
            tx_sr   <= '0;
            tx_cnt  <= '0;
        end else begin
            bit_cnt <= cnt_n;
            hdr_sr  <= hdr_n;
            data_sr <= data_n;
            if (frame_valid) begin
                rx_q <= rx_payload;
            end
            if (ld_tx) begin
                tx_sr  <= tx_data;
                tx_cnt <= '0;
            end else if (shift_edge && state != ST_IDLE) begin
                tx_sr  <= {tx_sr[DW-2:0], 1'b0};
                tx_cnt <= (tx_cnt == TX_END) ? tx_cnt : tx_cnt + 1'b1;
            end
        end
    end

    assign miso = (state != ST_IDLE) && !cs_s && (tx_cnt != TX_END) && tx_sr[DW-1];

endmodule

// File: tb/tb_spi_frame_xcvr.sv
// tb/tb_spi_frame_xcvr.sv - directed self-checking bench for spi_frame_xcvr (both SCK_EDGE settings)
module tb_spi_frame_xcvr;

`ifdef SPI_PARITY_EN
    localparam int FB = 51;
`else
    localparam int FB = 50;
`endif

    logic        clk = 1'b0;
    logic        rstn, sck, cs0, cs1, mosi;
    logic [13:0] tx0, tx1;
    logic        miso0, miso1;
    logic [41:0] rx0, rx1;
    logic        fv0, he0, se0, fv1, he1, se1;
`ifdef SPI_PARITY_EN
    logic        pe0, pe1;
    int          pe0_n = 0;
`endif

    int          checks = 0;
    int          failures = 0;
    int          fv0_n = 0, he0_n = 0, se0_n = 0, fv1_n = 0, he1_n = 0, se1_n = 0;
    time         fv0_t = 0, last_samp_t = 0;
    logic [41:0] rx0_at_fv = '0;
    logic [41:0] rx1_q[$];
    logic [63:0] miso_cap;

    always #5 clk = ~clk;

    spi_frame_xcvr #(.SCK_EDGE(1'b0)) dut0 (
        .clk(clk), .rstn(rstn), .sck(sck), .cs(cs0), .mosi(mosi), .miso(miso0),
        .tx_data(tx0), .rx_data(rx0), .frame_valid(fv0), .hdr_err(he0), .short_err(se0)
`ifdef SPI_PARITY_EN
        , .par_err(pe0)
`endif
    );

    spi_frame_xcvr #(.SCK_EDGE(1'b1)) dut1 (
        .clk(clk), .rstn(rstn), .sck(sck), .cs(cs1), .mosi(mosi), .miso(miso1),
        .tx_data(tx1), .rx_data(rx1), .frame_valid(fv1), .hdr_err(he1), .short_err(se1)
`ifdef SPI_PARITY_EN
        , .par_err(pe1)
`endif
    );

    always @(negedge clk) begin
        if (fv0 === 1'b1) begin fv0_n++; fv0_t = $time; rx0_at_fv = rx0; end
        if (he0 === 1'b1) he0_n++;
        if (se0 === 1'b1) se0_n++;
        if (fv1 === 1'b1) begin fv1_n++; rx1_q.push_back(rx1); end
        if (he1 === 1'b1) he1_n++;
        if (se1 === 1'b1) se1_n++;
`ifdef SPI_PARITY_EN
        if (pe0 === 1'b1) pe0_n++;
`endif
    end

    function automatic logic [127:0] mk_frame(input logic [7:0] h, input logic [13:0] c0,
                                              input logic [13:0] c1, input logic [13:0] c2);
        logic [127:0] f;
`ifdef SPI_PARITY_EN
        f = {77'd0, h, c0, c1, c2, ^{c0, c1, c2}};
`else
        f = {78'd0, h, c0, c1, c2};
`endif
        return f;
    endfunction

    task automatic set_cs(input bit m, input logic v);
        if (m) cs1 = v; else cs0 = v;
    endtask

    // Sends bits[n-1] first. m selects the target: 0 -> dut0 (idle sck low), 1 -> dut1 (idle sck high).
    task automatic send_bits(input logic [127:0] bits, input int n, input int h, input bit m,
                             input bit cs_with_last, input bit raise_cs);
        if (sck !== m) begin
            sck = m;
            repeat (4) @(negedge clk);
        end
        set_cs(m, 1'b0);
        repeat (h) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            mosi = bits[n-1-i];
            repeat (h) @(negedge clk);
            if (i < 64) miso_cap[i] = m ? miso1 : miso0;
            sck = ~m;
            if (i == n - 1) begin
                last_samp_t = $time;
                if (cs_with_last) set_cs(m, 1'b1);
            end
            repeat (h) @(negedge clk);
            sck = m;
        end
        if (raise_cs && !cs_with_last) begin
            repeat (h) @(negedge clk);
            set_cs(m, 1'b1);
        end
    endtask

    task automatic test_reset;
        checks++;
        if ({fv0, he0, se0} !== 3'b000) begin
            failures++; $display("FAIL reset_strobes0 got=%b exp=000", {fv0, he0, se0});
        end
        checks++;
        if ({fv1, he1, se1} !== 3'b000) begin
            failures++; $display("FAIL reset_strobes1 got=%b exp=000", {fv1, he1, se1});
        end
        checks++;
        if ({miso0, miso1} !== 2'b00) begin
            failures++; $display("FAIL reset_miso got=%b exp=00", {miso0, miso1});
        end
        checks++;
        if (rx0 !== 42'd0) begin
            failures++; $display("FAIL reset_rx0 got=%h exp=0", rx0);
        end
        checks++;
        if (rx1 !== 42'd0) begin
            failures++; $display("FAIL reset_rx1 got=%h exp=0", rx1);
        end
    endtask

    task automatic test_nominal;
        int f0, h0, s0;
        logic [13:0] mg;
        f0 = fv0_n; h0 = he0_n; s0 = se0_n;
        tx0 = 14'h2AAA;
        send_bits(mk_frame(8'hA5, 14'h1234, 14'h0ABC, 14'h3FFF), FB, 4, 1'b0, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        checks++;
        if ((fv0_n - f0) !== 1) begin
            failures++; $display("FAIL nominal_fv_count got=%0d exp=1", fv0_n - f0);
        end
        checks++;
        if (rx0 !== {14'h3FFF, 14'h0ABC, 14'h1234}) begin
            failures++; $display("FAIL nominal_rx got=%h exp=%h", rx0, {14'h3FFF, 14'h0ABC, 14'h1234});
        end
        checks++;
        if (rx0_at_fv !== {14'h3FFF, 14'h0ABC, 14'h1234}) begin
            failures++; $display("FAIL nominal_rx_at_strobe got=%h exp=%h", rx0_at_fv, {14'h3FFF, 14'h0ABC, 14'h1234});
        end
        checks++;
        if ((fv0_t - last_samp_t) !== 30) begin
            failures++; $display("FAIL nominal_latency got=%0t exp=30", fv0_t - last_samp_t);
        end
        for (int i = 0; i < 14; i++) mg[13-i] = miso_cap[i];
        checks++;
        if (mg !== 14'b10101010101010) begin
            failures++; $display("FAIL nominal_miso got=%b exp=10101010101010", mg);
        end
        checks++;
        if (miso_cap[FB-1:14] !== '0) begin
            failures++; $display("FAIL nominal_miso_tail got=%h exp=0", miso_cap[FB-1:14]);
        end
        checks++;
        if ((he0_n - h0) !== 0 || (se0_n - s0) !== 0) begin
            failures++; $display("FAIL nominal_errs got=%0d/%0d exp=0/0", he0_n - h0, se0_n - s0);
        end
    endtask

    task automatic test_hdr_err;
        int f0, h0;
        f0 = fv0_n; h0 = he0_n;
        send_bits(mk_frame(8'h5A, 14'h1111, 14'h2222, 14'h3333), FB, 3, 1'b0, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        checks++;
        if ((he0_n - h0) !== 1) begin
            failures++; $display("FAIL hdr_err_count got=%0d exp=1", he0_n - h0);
        end
        checks++;
        if ((fv0_n - f0) !== 0) begin
            failures++; $display("FAIL hdr_no_fv got=%0d exp=0", fv0_n - f0);
        end
        checks++;
        if (rx0 !== {14'h3FFF, 14'h0ABC, 14'h1234}) begin
            failures++; $display("FAIL hdr_rx_held got=%h exp=%h", rx0, {14'h3FFF, 14'h0ABC, 14'h1234});
        end
        f0 = fv0_n;
        send_bits(mk_frame(8'hA5, 14'h0001, 14'h2000, 14'h1555), FB, 3, 1'b0, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        checks++;
        if ((fv0_n - f0) !== 1) begin
            failures++; $display("FAIL hdr_recover_fv got=%0d exp=1", fv0_n - f0);
        end
        checks++;
        if (rx0 !== {14'h1555, 14'h2000, 14'h0001}) begin
            failures++; $display("FAIL hdr_recover_rx got=%h exp=%h", rx0, {14'h1555, 14'h2000, 14'h0001});
        end
    endtask

    task automatic test_short_and_long;
        int f0, s0;
        logic [127:0] fr;
        fr = mk_frame(8'hA5, 14'h1234, 14'h0ABC, 14'h3FFF);
        f0 = fv0_n; s0 = se0_n;
        send_bits(fr >> (FB - 20), 20, 3, 1'b0, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        checks++;
        if ((se0_n - s0) !== 1 || (fv0_n - f0) !== 0) begin
            failures++; $display("FAIL short_20 got se=%0d fv=%0d exp se=1 fv=0", se0_n - s0, fv0_n - f0);
        end
        checks++;
        if (rx0 !== {14'h1555, 14'h2000, 14'h0001}) begin
            failures++; $display("FAIL short_rx_held got=%h exp=%h", rx0, {14'h1555, 14'h2000, 14'h0001});
        end
        f0 = fv0_n; s0 = se0_n;
        send_bits(fr, FB, 3, 1'b0, 1'b1, 1'b1);
        repeat (8) @(negedge clk);
        checks++;
        if ((se0_n - s0) !== 1 || (fv0_n - f0) !== 0) begin
            failures++; $display("FAIL cs_with_last got se=%0d fv=%0d exp se=1 fv=0", se0_n - s0, fv0_n - f0);
        end
        checks++;
        if (rx0 !== {14'h1555, 14'h2000, 14'h0001}) begin
            failures++; $display("FAIL cs_with_last_rx got=%h exp=%h", rx0, {14'h1555, 14'h2000, 14'h0001});
        end
        f0 = fv0_n; s0 = se0_n;
        send_bits((fr << 10) | 128'h3FF, FB + 10, 3, 1'b0, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        checks++;
        if ((fv0_n - f0) !== 1 || (se0_n - s0) !== 0) begin
            failures++; $display("FAIL long_frame got fv=%0d se=%0d exp fv=1 se=0", fv0_n - f0, se0_n - s0);
        end
        checks++;
        if (rx0 !== {14'h3FFF, 14'h0ABC, 14'h1234}) begin
            failures++; $display("FAIL long_rx got=%h exp=%h", rx0, {14'h3FFF, 14'h0ABC, 14'h1234});
        end
    endtask

    task automatic test_reset_mid;
        int f0, h0, s0;
        f0 = fv0_n; h0 = he0_n; s0 = se0_n;
        send_bits(mk_frame(8'hA5, 14'h0F0F, 14'h0F0F, 14'h0F0F) >> (FB - 30), 30, 3, 1'b0, 1'b0, 1'b0);
        rstn = 1'b0;
        @(negedge clk);
        checks++;
        if (rx0 !== 42'd0 || miso0 !== 1'b0 || {fv0, he0, se0} !== 3'b000) begin
            failures++; $display("FAIL reset_mid_outputs got rx=%h miso=%b strobes=%b exp 0", rx0, miso0, {fv0, he0, se0});
        end
        cs0 = 1'b1;
        repeat (4) @(negedge clk);
        rstn = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if ((fv0_n - f0) !== 0 || (he0_n - h0) !== 0 || (se0_n - s0) !== 0) begin
            failures++; $display("FAIL reset_mid_strobes got fv=%0d he=%0d se=%0d exp 0", fv0_n - f0, he0_n - h0, se0_n - s0);
        end
        send_bits(mk_frame(8'hA5, 14'h3C3C, 14'h0F0F, 14'h2468), FB, 3, 1'b0, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        checks++;
        if ((fv0_n - f0) !== 1) begin
            failures++; $display("FAIL reset_mid_next_fv got=%0d exp=1", fv0_n - f0);
        end
        checks++;
        if (rx0 !== {14'h2468, 14'h0F0F, 14'h3C3C}) begin
            failures++; $display("FAIL reset_mid_next_rx got=%h exp=%h", rx0, {14'h2468, 14'h0F0F, 14'h3C3C});
        end
    endtask

    task automatic test_back_to_back;
        int f1, s1, h1;
        f1 = fv1_n; s1 = se1_n; h1 = he1_n;
        rx1_q.delete();
        tx1 = 14'h0000;
        send_bits(mk_frame(8'hA5, 14'h0F0F, 14'h3001, 14'h2222), FB, 2, 1'b1, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        send_bits(mk_frame(8'hA5, 14'h0155, 14'h1FFF, 14'h0000), FB, 2, 1'b1, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        checks++;
        if ((fv1_n - f1) !== 2) begin
            failures++; $display("FAIL b2b_fv_count got=%0d exp=2", fv1_n - f1);
        end
        checks++;
        if ((se1_n - s1) !== 0 || (he1_n - h1) !== 0) begin
            failures++; $display("FAIL b2b_errs got se=%0d he=%0d exp 0", se1_n - s1, he1_n - h1);
        end
        checks++;
        if (rx1_q.size() < 2) begin
            failures++; $display("FAIL b2b_frames got=%0d exp=2", rx1_q.size());
        end else begin
            if (rx1_q[0] !== {14'h2222, 14'h3001, 14'h0F0F}) begin
                failures++; $display("FAIL b2b_frame0 got=%h exp=%h", rx1_q[0], {14'h2222, 14'h3001, 14'h0F0F});
            end
            checks++;
            if (rx1_q[1] !== {14'h0000, 14'h1FFF, 14'h0155}) begin
                failures++; $display("FAIL b2b_frame1 got=%h exp=%h", rx1_q[1], {14'h0000, 14'h1FFF, 14'h0155});
            end
        end
    endtask

`ifdef SPI_PARITY_EN
    task automatic test_parity;
        int f0, p0;
        f0 = fv0_n; p0 = pe0_n;
        send_bits({77'd0, 8'hA5, 14'h1234, 14'h0ABC, 14'h3FFF, 1'b0}, FB, 3, 1'b0, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        checks++;
        if ((fv0_n - f0) !== 1 || (pe0_n - p0) !== 0) begin
            failures++; $display("FAIL parity_good got fv=%0d pe=%0d exp fv=1 pe=0", fv0_n - f0, pe0_n - p0);
        end
        f0 = fv0_n; p0 = pe0_n;
        send_bits({77'd0, 8'hA5, 14'h1234, 14'h0ABC, 14'h3FFF, 1'b1}, FB, 3, 1'b0, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        checks++;
        if ((fv0_n - f0) !== 0 || (pe0_n - p0) !== 1) begin
            failures++; $display("FAIL parity_bad got fv=%0d pe=%0d exp fv=0 pe=1", fv0_n - f0, pe0_n - p0);
        end
        checks++;
        if (rx0 !== {14'h3FFF, 14'h0ABC, 14'h1234}) begin
            failures++; $display("FAIL parity_rx_held got=%h exp=%h", rx0, {14'h3FFF, 14'h0ABC, 14'h1234});
        end
    endtask
`endif

    initial begin
        rstn = 1'b0;
        sck  = 1'b0;
        cs0  = 1'b1;
        cs1  = 1'b1;
        mosi = 1'b0;
        tx0  = 14'h0000;
        tx1  = 14'h0000;
        miso_cap = '0;
        repeat (3) @(negedge clk);
        test_reset;
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        test_nominal;
        test_hdr_err;
        test_short_and_long;
        test_reset_mid;
        test_back_to_back;
`ifdef SPI_PARITY_EN
        test_parity;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
